// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone classic single-transfer initiator fed by a command stream
// Each accepted command becomes one CYC/STB transfer; the result (read data or timeout) returns on the response stream.
module wb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam bit                   LP_TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] LP_TO_LAST = LP_TO_EN ? TIMEOUT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t               r_state;
  state_t               w_next_state;
  logic [TIMEOUT_W-1:0] r_to_cnt;
  logic                 r_cyc;
  logic                 r_we;
  logic [3:0]           r_sel;
  logic [31:0]          r_adr;
  logic [31:0]          r_dat;
  logic [31:0]          r_rsp_dat;
  logic                 r_rsp_err;

  logic w_cmd_hs;
  logic w_rsp_hs;
  logic w_ack;
  logic w_expire;

  assign w_cmd_hs = (r_state == S_IDLE) && cmd_valid_i;
  assign w_rsp_hs = (r_state == S_RESP) && rsp_ready_i;
  assign w_ack    = (r_state == S_BUS) && wbm_ack_i;
  // ACK takes priority, so expiry only counts on an edge without ACK.
  assign w_expire = LP_TO_EN && (r_state == S_BUS) && !wbm_ack_i && (r_to_cnt == LP_TO_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_cmd_hs) w_next_state = S_BUS;
      S_BUS:   if (w_ack || w_expire) w_next_state = S_RESP;
      S_RESP:  if (w_rsp_hs) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = (r_state == S_IDLE);
    rsp_valid_o = (r_state == S_RESP);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_to_cnt  <= '0;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
    end else if (w_cmd_hs) begin
      r_to_cnt <= '0;
      r_cyc    <= 1'b1;
      r_we     <= cmd_we_i;
      r_sel    <= cmd_sel_i;
      r_adr    <= cmd_adr_i;
      r_dat    <= cmd_dat_i;
    end else if (w_ack) begin
      r_cyc     <= 1'b0;
      r_rsp_dat <= r_we ? 32'h0 : wbm_dat_i;
      r_rsp_err <= 1'b0;
    end else if (w_expire) begin
      r_cyc     <= 1'b0;
      r_rsp_dat <= 32'h0;
      r_rsp_err <= 1'b1;
    end else if (r_state == S_BUS) begin
      r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
    end
  end

  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign rsp_dat_o = r_rsp_dat;
  assign rsp_err_o = r_rsp_err;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - self-checking bench for wb_cmd_master
// Transaction-level model checked every cycle, plus directed cycle-exact scenarios.
module tb_wb_cmd_master;

  localparam int TO = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_cmd_master #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(3)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int n_rsp  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } cmd_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  // Model: one command in flight at most, responses queued until consumed.
  cmd_t m_last;
  rsp_t m_out;
  rsp_t m_q[$];
  logic m_busy = 1'b0;
  int   m_wait = 0;
  logic chk_en = 1'b0;

  always @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      m_last = '0;
      m_out  = '0;
      m_busy = 1'b0;
      m_wait = 0;
      m_q.delete();
      chk_en = 1'b1;
    end else if (m_busy) begin
      if (wbm_ack_i) begin
        m_out.dat = m_last.we ? 32'h0 : wbm_dat_i;
        m_out.err = 1'b0;
        m_q.push_back(m_out);
        m_busy = 1'b0;
      end else if (TO != 0 && m_wait + 1 == TO) begin
        m_out.dat = 32'h0;
        m_out.err = 1'b1;
        m_q.push_back(m_out);
        m_busy = 1'b0;
      end else begin
        m_wait++;
      end
    end else if (m_q.size() != 0) begin
      if (rsp_ready_i) void'(m_q.pop_front());
    end else if (cmd_valid_i) begin
      m_last.we  = cmd_we_i;
      m_last.adr = cmd_adr_i;
      m_last.dat = cmd_dat_i;
      m_last.sel = cmd_sel_i;
      m_busy     = 1'b1;
      m_wait     = 0;
    end
  end

  always @(posedge wb_clk_i) begin
    if (!wb_rst_i && rsp_valid_o && rsp_ready_i) n_rsp++;
  end

  always @(negedge wb_clk_i) begin
    if (chk_en) begin
      check1("m_cmd_ready", cmd_ready_o, !m_busy && (m_q.size() == 0));
      check1("m_rsp_valid", rsp_valid_o, m_q.size() != 0);
      check1("m_cyc", wbm_cyc_o, m_busy);
      check1("m_stb", wbm_stb_o, m_busy);
      check1("m_we", wbm_we_o, m_last.we);
      check32("m_adr", wbm_adr_o, m_last.adr);
      check32("m_dat", wbm_dat_o, m_last.dat);
      check32("m_sel", {28'h0, wbm_sel_o}, {28'h0, m_last.sel});
      check32("m_rsp_dat", rsp_dat_o, m_out.dat);
      check1("m_rsp_err", rsp_err_o, m_out.err);
    end
  end

  // Random-latency slave, active only during the back-to-back phase.
  logic auto_slave = 1'b0;
  int   s_cnt = 0;
  int   s_dly = 1;

  always @(negedge wb_clk_i) begin
    if (auto_slave) begin
      if (wbm_cyc_o) begin
        if (s_cnt == 0) s_dly = $urandom_range(1, 3);
        s_cnt++;
        wbm_ack_i = (s_cnt == s_dly);
        wbm_dat_i = (s_cnt == s_dly) ? $urandom : 32'h0;
      end else begin
        s_cnt     = 0;
        wbm_ack_i = 1'b0;
      end
    end
  end

  task automatic put_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = '0;
    cmd_dat_i   = '0;
    cmd_sel_i   = '0;
    rsp_ready_i = 1'b1;
    wbm_ack_i   = 1'b0;
    wbm_dat_i   = '0;

    repeat (2) @(negedge wb_clk_i);
    check1("rst_cmd_ready", cmd_ready_o, 1'b1);
    check1("rst_rsp_valid", rsp_valid_o, 1'b0);
    check1("rst_cyc", wbm_cyc_o, 1'b0);
    check32("rst_adr", wbm_adr_o, 32'h0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // Write, ACK in 2nd STB cycle
    put_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    cmd_adr_i   = 32'hFFFF_FFFF;
    cmd_dat_i   = 32'h0;
    check1("wr_c1_stb", wbm_stb_o, 1'b1);
    check32("wr_c1_adr", wbm_adr_o, 32'h3000_0004);
    @(negedge wb_clk_i);
    check1("wr_c2_stb", wbm_stb_o, 1'b1);
    check1("wr_c2_we", wbm_we_o, 1'b1);
    check32("wr_c2_dat", wbm_dat_o, 32'hDEAD_BEEF);
    check32("wr_c2_sel", {28'h0, wbm_sel_o}, 32'hF);
    wbm_ack_i = 1'b1;
    @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    check1("wr_c3_rsp_valid", rsp_valid_o, 1'b1);
    check32("wr_c3_rsp_dat", rsp_dat_o, 32'h0);
    check1("wr_c3_rsp_err", rsp_err_o, 1'b0);
    check1("wr_c3_cyc", wbm_cyc_o, 1'b0);
    @(negedge wb_clk_i);
    check1("wr_c4_cmd_ready", cmd_ready_o, 1'b1);

    // Read, ACK in 1st STB cycle
    put_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    check1("rd_c1_stb", wbm_stb_o, 1'b1);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h1234_5678;
    @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    check1("rd_c2_rsp_valid", rsp_valid_o, 1'b1);
    check32("rd_c2_rsp_dat", rsp_dat_o, 32'h1234_5678);
    @(negedge wb_clk_i);
    check1("rd_c3_cmd_ready", cmd_ready_o, 1'b1);

    // Timeout, no ACK
    put_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    for (int c = 1; c <= 4; c++) begin
      @(negedge wb_clk_i);
      cmd_valid_i = 1'b0;
      check1($sformatf("to_c%0d_stb", c), wbm_stb_o, 1'b1);
    end
    @(negedge wb_clk_i);
    check1("to_c5_stb", wbm_stb_o, 1'b0);
    check1("to_c5_rsp_valid", rsp_valid_o, 1'b1);
    check1("to_c5_rsp_err", rsp_err_o, 1'b1);
    check32("to_c5_rsp_dat", rsp_dat_o, 32'h0);
    @(negedge wb_clk_i);
    check1("to_c6_cmd_ready", cmd_ready_o, 1'b1);

    // ACK on the expiry cycle wins
    put_cmd(1'b0, 32'h3000_0024, 32'h0, 4'hF);
    for (int c = 1; c <= 3; c++) begin
      @(negedge wb_clk_i);
      cmd_valid_i = 1'b0;
    end
    @(negedge wb_clk_i);
    check1("toack_c4_stb", wbm_stb_o, 1'b1);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hCAFE_0001;
    @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    check1("toack_c5_rsp_valid", rsp_valid_o, 1'b1);
    check1("toack_c5_rsp_err", rsp_err_o, 1'b0);
    check32("toack_c5_rsp_dat", rsp_dat_o, 32'hCAFE_0001);
    @(negedge wb_clk_i);

    // Backpressure with a second command waiting
    rsp_ready_i = 1'b0;
    put_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    @(negedge wb_clk_i);
    put_cmd(1'b1, 32'h3000_0044, 32'hA5A5_A5A5, 4'h3);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h0BAD_F00D;
    @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    for (int i = 0; i < 10; i++) begin
      check1($sformatf("bp_%0d_rsp_valid", i), rsp_valid_o, 1'b1);
      check32($sformatf("bp_%0d_rsp_dat", i), rsp_dat_o, 32'h0BAD_F00D);
      check1($sformatf("bp_%0d_cmd_ready", i), cmd_ready_o, 1'b0);
      check1($sformatf("bp_%0d_cyc", i), wbm_cyc_o, 1'b0);
      @(negedge wb_clk_i);
    end
    rsp_ready_i = 1'b1;
    check1("bp_c12_rsp_valid", rsp_valid_o, 1'b1);
    @(negedge wb_clk_i);
    check1("bp_c13_cmd_ready", cmd_ready_o, 1'b1);
    check1("bp_c13_cyc", wbm_cyc_o, 1'b0);
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    check1("bp_c14_cyc", wbm_cyc_o, 1'b1);
    check32("bp_c14_adr", wbm_adr_o, 32'h3000_0044);
    check32("bp_c14_sel", {28'h0, wbm_sel_o}, 32'h3);
    wbm_ack_i = 1'b1;
    @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    check1("bp_c15_rsp_valid", rsp_valid_o, 1'b1);
    check32("bp_c15_rsp_dat", rsp_dat_o, 32'h0);
    @(negedge wb_clk_i);

    // Reset in the 2nd STB cycle, then a stray ACK in IDLE
    put_cmd(1'b1, 32'h3000_0080, 32'h1111_2222, 4'h1);
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    check1("rm_c1_stb", wbm_stb_o, 1'b1);
    @(negedge wb_clk_i);
    check1("rm_c2_stb", wbm_stb_o, 1'b1);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check1("rm_c3_cyc", wbm_cyc_o, 1'b0);
    check1("rm_c3_stb", wbm_stb_o, 1'b0);
    check1("rm_c3_we", wbm_we_o, 1'b0);
    check32("rm_c3_adr", wbm_adr_o, 32'h0);
    check32("rm_c3_dat", wbm_dat_o, 32'h0);
    check32("rm_c3_sel", {28'h0, wbm_sel_o}, 32'h0);
    check1("rm_c3_rsp_valid", rsp_valid_o, 1'b0);
    check1("rm_c3_cmd_ready", cmd_ready_o, 1'b1);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h7777_7777;
    @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    check1("stray_cmd_ready", cmd_ready_o, 1'b1);
    check1("stray_rsp_valid", rsp_valid_o, 1'b0);
    check1("stray_cyc", wbm_cyc_o, 1'b0);
    check32("stray_rsp_dat", rsp_dat_o, 32'h0);
    @(negedge wb_clk_i);

    // Back-to-back random traffic
    n_rsp      = 0;
    auto_slave = 1'b1;
    for (int i = 0; i < 16; i++) begin
      int t;
      put_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      t = 0;
      while (!cmd_ready_o && t < 40) begin
        @(negedge wb_clk_i);
        t++;
      end
      check1($sformatf("rnd_%0d_accept", i), cmd_ready_o, 1'b1);
      @(negedge wb_clk_i);
    end
    cmd_valid_i = 1'b0;
    begin
      int t;
      t = 0;
      while (n_rsp < 16 && t < 100) begin
        @(negedge wb_clk_i);
        t++;
      end
    end
    check32("rnd_rsp_count", 32'(n_rsp), 32'd16);
    auto_slave = 1'b0;
    wbm_ack_i  = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic single-transfer initiator for the user project. It turns commands from a valid/ready stream into one Wishbone read or write each, and returns the result (read data or timeout error) on a valid/ready response stream. It drives the same 32-bit Wishbone signal set that the user area exposes as a slave, so on-die sequencers can initiate transfers into the user slave bus or a bench bus, with a bounded wait per transfer.

## Interface

Parameters:
- TIMEOUT_CYCLES, default 255: maximum cycles STB is held waiting for ACK; 0 disables the timeout.
- TIMEOUT_W, default 8: counter width; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports (clocking fixed: one clock; reset is synchronous and active-high):
- wb_clk_i  in  1  sole clock; all state updates on its rising edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  32  byte address.
- cmd_dat_i  in  32  write data.
- cmd_sel_i  in  4  byte selects.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when high together with rsp_valid_o.
- rsp_dat_o  out  32  read data; 0 for writes and for timeouts.
- rsp_err_o  out  1  1 = timeout, no ACK received.
- wbm_cyc_o  out  1  Wishbone CYC.
- wbm_stb_o  out  1  Wishbone STB.
- wbm_we_o  out  1  Wishbone WE.
- wbm_sel_o  out  4  Wishbone SEL.
- wbm_adr_o  out  32  Wishbone ADR.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_ack_i  in  1  Wishbone ACK.
- wbm_dat_i  in  32  Wishbone read data.

## Operation

- FSM states: IDLE, BUS, RESP. Reset state is IDLE.
- IDLE:
  - cmd_ready_o = 1.
  - On a command handshake: latch we/adr/dat/sel into the wbm_* registers, clear the timeout counter, go to BUS.
- BUS:
  - wbm_cyc_o = wbm_stb_o = 1; all wbm_* outputs stay stable.
  - On a rising edge with wbm_ack_i = 1:
    - capture rsp_dat_o = wbm_dat_i for a read, 0 for a write;
    - set rsp_err_o = 0;
    - go to RESP.
  - Otherwise, if TIMEOUT_CYCLES ≠ 0 and the counter equals TIMEOUT_CYCLES−1: set rsp_dat_o = 0, rsp_err_o = 1, go to RESP.
  - Otherwise the counter increments.
  - If ACK and timeout expiry fall on the same edge, ACK wins.
- RESP:
  - rsp_valid_o = 1; rsp_dat_o and rsp_err_o hold.
  - On a response handshake, go to IDLE.
  - Backpressure on rsp_ready_i stalls indefinitely.
- wbm_ack_i is ignored outside BUS; a stray ACK has no effect.
- CYC and STB are always equal: single transfers only, no bursts, no RTY/ERR inputs.
- Address, data and select pass through unmodified; no alignment checks.

## Timing

- All outputs are registered, except cmd_ready_o and rsp_valid_o, which are decoded from the state register.
- Reset values:
  - cmd_ready_o = 1 (IDLE); rsp_valid_o = 0;
  - rsp_dat_o = 0; rsp_err_o = 0;
  - wbm_cyc_o = wbm_stb_o = wbm_we_o = 0;
  - wbm_sel_o = 0; wbm_adr_o = 0; wbm_dat_o = 0.
- Cycle numbering: command handshake in cycle 0.
  - CYC/STB are high from cycle 1.
  - With ACK high in cycle k (k ≥ 1), CYC/STB drop in cycle k+1 and rsp_valid_o rises in cycle k+1.
  - With rsp_ready_i tied high, cmd_ready_o is high again in cycle k+2.
  - Best-case throughput is one transaction per 3 cycles.
- Timeout: with no ACK, STB is high for exactly TIMEOUT_CYCLES cycles (cycles 1..TIMEOUT_CYCLES). rsp_valid_o rises with rsp_err_o = 1 in cycle TIMEOUT_CYCLES+1.
- Reset asserted mid-transfer: on the next edge, CYC/STB drop, the FSM returns to IDLE and all outputs take their reset values. The pending response is discarded.
- Command inputs are sampled only on the handshake edge; later changes do not affect the transfer in flight.

## Test plan

- Write: cmd we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; slave ACKs in the 2nd STB cycle.
  - Required: CYC/STB high in cycles 1–2 with adr/dat/sel/we stable.
  - Required: rsp_valid_o in cycle 3 with rsp_dat_o = 0, rsp_err_o = 0.
- Read: cmd we=0, adr=0x3000_0010; slave returns 0x1234_5678 with ACK in the 1st STB cycle.
  - Required: rsp_dat_o = 0x1234_5678 in cycle 2.
  - Required: cmd_ready_o high in cycle 3.
- Timeout: TIMEOUT_CYCLES = 4, no ACK.
  - Required: STB high in cycles 1–4 only.
  - Required: rsp_valid_o = 1, rsp_err_o = 1, rsp_dat_o = 0 in cycle 5.
  - Repeat with ACK in cycle 4: required rsp_err_o = 0 (ACK wins).
- Backpressure: rsp_ready_i held low for 10 cycles after a read.
  - Required: rsp_valid_o/rsp_dat_o held stable, cmd_ready_o = 0 and no new CYC throughout.
  - Required: the second queued command is issued only after the response handshake.
- Reset mid-transfer: assert wb_rst_i in the 2nd STB cycle.
  - Required: all outputs at reset values on the next edge, and no response emitted.
  - Required: a stray ACK in IDLE afterwards causes no state change.
- Back-to-back: 16 random read/write commands against a slave model with random 1–3 cycle ACK delay and rsp_ready_i tied high.
  - Required: the responses match the slave model in order.
  - Required: CYC is never high outside BUS.
